// File: rtl/line_drawing_control.sv
// Sequencing FSM for the Bresenham line datapath: issues load/swap/setup/loop
// strobes in order, hands each pixel to the plot port via req/ack, pulses done.
module line_drawing_control (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic steep,
  input  logic x0_gt_x1,
  input  logic x_lte_x1,
  input  logic err_ge0,
  input  logic plot_ack,
  output logic ld,
  output logic swap_1,
  output logic swap_2,
  output logic ld_delta_x,
  output logic ld_delta_y,
  output logic ld_y_step,
  output logic ld_err,
  output logic ld_x,
  output logic ld_y,
  output logic add_dy_err,
  output logic decr_err,
  output logic incr_x,
  output logic incr_y,
  output logic plot_req,
  output logic steep_r,
  output logic busy,
  output logic done
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_STEEP, S_ORDER, S_DELTA,
    S_INIT, S_PLOT, S_ACC, S_ADJ, S_DONE
  } state_t;

  state_t state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      steep_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_LOAD;
        S_LOAD: begin
          steep_r <= 1'b0;
          state   <= S_STEEP;
        end
        S_STEEP: begin
          steep_r <= steep;
          state   <= S_ORDER;
        end
        S_ORDER: state <= S_DELTA;
        S_DELTA: state <= S_INIT;
        S_INIT:  state <= S_PLOT;
        S_PLOT:  if (plot_ack) state <= S_ACC;
        S_ACC:   state <= S_ADJ;
        S_ADJ:   state <= x_lte_x1 ? S_PLOT : S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode from state alone, except the three flag-qualified ones,
  // which must follow the datapath flag within the same cycle.
  // NOTE: every output gets a default before the case, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    ld         = 1'b0;
    swap_1     = 1'b0;
    swap_2     = 1'b0;
    ld_delta_x = 1'b0;
    ld_delta_y = 1'b0;
    ld_y_step  = 1'b0;
    ld_err     = 1'b0;
    ld_x       = 1'b0;
    ld_y       = 1'b0;
    add_dy_err = 1'b0;
    decr_err   = 1'b0;
    incr_x     = 1'b0;
    incr_y     = 1'b0;
    plot_req   = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_LOAD:  ld = 1'b1;
      S_STEEP: swap_1 = steep;
      S_ORDER: swap_2 = x0_gt_x1;
      S_DELTA: begin
        ld_delta_x = 1'b1;
        ld_delta_y = 1'b1;
        ld_y_step  = 1'b1;
      end
      S_INIT: begin
        ld_err = 1'b1;
        ld_x   = 1'b1;
        ld_y   = 1'b1;
      end
      S_PLOT:  plot_req = 1'b1;
      S_ACC: begin
        add_dy_err = 1'b1;
        incr_x     = 1'b1;
      end
      S_ADJ: begin
        incr_y   = err_ge0;
        decr_err = err_ge0;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
